reg_bus_master: RTL and testbench

Initiator for the microcontroller's memory-mapped register bus. It accepts single read or write commands on a valid/ready request port and drives the register-file side signals `addr`, `r_wn`, `wdata` and `wxfc`. For reads, it waits for the responder's `rxfc` handshake and captures `rdata`. It returns one response per command, or an error if the responder does not answer within a bounded number of cycles. It sits between the command source (core load/store unit or debug command parser) and the register file.

---
 rtl/reg_bus_master.sv | 125 ++++++++++++
 tb/tb_reg_bus_master.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/reg_bus_master.sv
// Register-bus initiator: turns single read/write commands into addr/r_wn/wdata/wxfc
// bus cycles and returns one response per command, with a read timeout.
module reg_bus_master #(
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] addr,
  output logic              r_wn,
  output logic [DATA_W-1:0] wdata,
  output logic              wxfc,
  input  logic              rxfc,
  input  logic [DATA_W-1:0] rdata
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata_nxt, rsp_rdata_nxt;
  logic              r_wn_nxt, rsp_err_nxt;
  logic              req_hs, rsp_hs;

  assign req_hs = req_valid & req_ready;
  assign rsp_hs = rsp_valid & rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // r_wn already holds the latched direction during ISSUE
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (req_hs) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = r_wn ? S_WAIT : S_RESP;
      S_WAIT:  if (rxfc || (cnt == CNT_LAST)) state_nxt = S_RESP;
      S_RESP:  if (rsp_hs) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    addr_nxt      = addr;
    wdata_nxt     = wdata;
    r_wn_nxt      = r_wn;
    rsp_rdata_nxt = rsp_rdata;
    rsp_err_nxt   = rsp_err;
    cnt_nxt       = cnt;
    unique case (state)
      S_IDLE: begin
        if (req_hs) begin
          addr_nxt  = req_addr;
          wdata_nxt = req_wdata;
          r_wn_nxt  = ~req_write;
        end
      end
      S_ISSUE: begin
        cnt_nxt = '0;
        if (!r_wn) begin
          rsp_rdata_nxt = '0;
          rsp_err_nxt   = 1'b0;
        end
      end
      S_WAIT: begin
        // rxfc on the last WAIT cycle takes priority over the timeout
        if (rxfc) begin
          rsp_rdata_nxt = rdata;
          rsp_err_nxt   = 1'b0;
        end else if (cnt == CNT_LAST) begin
          rsp_rdata_nxt = '1;
          rsp_err_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_hs) r_wn_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  // Handshake/strobe outputs are registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      wxfc      <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      r_wn      <= 1'b1;
      cnt       <= '0;
    end else begin
      req_ready <= (state_nxt == S_IDLE);
      rsp_valid <= (state_nxt == S_RESP);
      wxfc      <= (state_nxt == S_ISSUE);
      rsp_rdata <= rsp_rdata_nxt;
      rsp_err   <= rsp_err_nxt;
      addr      <= addr_nxt;
      wdata     <= wdata_nxt;
      r_wn      <= r_wn_nxt;
      cnt       <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_reg_bus_master.sv
// Bench for reg_bus_master: directed cases then random commands, each checked
// against a per-command latency/response model.
module tb_reg_bus_master;
  localparam int unsigned ADDR_W  = 11;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready, req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid, rsp_ready, rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] addr;
  logic              r_wn, wxfc, rxfc;
  logic [DATA_W-1:0] wdata, rdata;

  int checks = 0;
  int errors = 0;

  reg_bus_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .addr(addr), .r_wn(r_wn), .wdata(wdata), .wxfc(wxfc), .rxfc(rxfc), .rdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_rsp_err"},   32'(rsp_err), 32'd0);
    chk({tag, "_addr"},      32'(addr), 32'd0);
    chk({tag, "_wdata"},     wdata, 32'd0);
    chk({tag, "_r_wn"},      32'(r_wn), 32'd1);
    chk({tag, "_wxfc"},      32'(wxfc), 32'd0);
  endtask

  // Called at a negedge while the DUT is idle. delay = WAIT cycles before rxfc
  // (delay >= TIMEOUT means the responder never answers).
  task automatic do_cmd(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input int unsigned delay, input logic [DATA_W-1:0] rd,
                        input int unsigned hold, input logic pulse_issue);
    logic              exp_err;
    logic [DATA_W-1:0] exp_data;
    int unsigned       wait_cycles;
    exp_err     = !wr && (delay >= TIMEOUT);
    exp_data    = wr ? 32'd0 : (exp_err ? 32'hFFFF_FFFF : rd);
    wait_cycles = wr ? 0 : (exp_err ? TIMEOUT : delay + 1);

    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    chk("idle_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom; req_wdata = $urandom;
    chk("issue_wxfc",  32'(wxfc), 32'd1);
    chk("issue_addr",  32'(addr), 32'(a));
    chk("issue_wdata", wdata, d);
    chk("issue_r_wn",  32'(r_wn), 32'(!wr));
    chk("issue_rsp_valid", 32'(rsp_valid), 32'd0);
    rxfc  = pulse_issue;
    rdata = $urandom;
    for (int unsigned c = 0; c < wait_cycles; c++) begin
      @(negedge clk);
      chk("wait_wxfc",      32'(wxfc), 32'd0);
      chk("wait_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("wait_r_wn",      32'(r_wn), 32'd1);
      rxfc      = (c == delay);
      rdata     = (c == delay) ? rd : $urandom;
      rsp_ready = 1'($urandom);
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    rxfc      = 1'($urandom);
    rdata     = $urandom;
    chk("resp_valid", 32'(rsp_valid), 32'd1);
    chk("resp_rdata", rsp_rdata, exp_data);
    chk("resp_err",   32'(rsp_err), 32'(exp_err));
    chk("resp_wxfc",  32'(wxfc), 32'd0);
    for (int unsigned h = 0; h < hold; h++) begin
      req_valid = 1'b1; req_write = 1'($urandom); req_addr = $urandom;
      @(negedge clk);
      chk("hold_valid",     32'(rsp_valid), 32'd1);
      chk("hold_rdata",     rsp_rdata, exp_data);
      chk("hold_err",       32'(rsp_err), 32'(exp_err));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      chk("hold_wxfc",      32'(wxfc), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    rxfc      = 1'b0;
    chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_req_ready", 32'(req_ready), 32'd1);
    chk("post_r_wn",      32'(r_wn), 32'd1);
    chk("post_addr",      32'(addr), 32'(a));
    chk("post_wdata",     wdata, d);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; rxfc = 1'b0; rdata = '0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    do_cmd(1'b1, 11'h004, 32'hA5A5_0001, 0, 32'h0, 0, 1'b0);
    do_cmd(1'b0, 11'h010, 32'h0, 2, 32'h1234_5678, 0, 1'b0);
    do_cmd(1'b0, 11'h020, 32'h0, 100, 32'h0, 0, 1'b0);
    do_cmd(1'b0, 11'h030, 32'h0, TIMEOUT - 1, 32'h0000_00C3, 0, 1'b1);
    do_cmd(1'b1, 11'h040, 32'hDEAD_BEEF, 0, 32'h0, 5, 1'b0);
    do_cmd(1'b0, 11'h044, 32'h0, 0, 32'hCAFE_0003, 5, 1'b1);

    // reset in the middle of a read
    req_valid = 1'b1; req_write = 1'b0; req_addr = 11'h055; req_wdata = 32'h1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midwait_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("after_reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("after_reset_wxfc",      32'(wxfc), 32'd0);
    end
    do_cmd(1'b0, 11'h066, 32'h0, 4, 32'h0BAD_F00D, 1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      do_cmd(1'($urandom), 11'($urandom), $urandom, $urandom_range(0, TIMEOUT + 3),
             $urandom, $urandom_range(0, 3), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
